// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - raster timing generator with selectable test patterns
module video_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEnable,
    input  logic [2:0]  iPattern,
    input  logic [23:0] iColor,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        oHSync,
    output logic        oVSync,
    output logic        oLineValid,
    output logic        oFrameValid,
    output logic [15:0] oFrameCnt,
    output logic        oBusy
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    // Narrow rasters still get a usable bar width instead of zero.
    localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT_END = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT_END = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEGIN  = 16'(H_ACTIVE + H_FRONT);
    localparam logic [15:0] HS_END    = 16'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [15:0] VS_BEGIN  = 16'(V_ACTIVE + V_FRONT);
    localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [15:0] BAR_LAST  = 16'(BAR_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [15:0] hCnt;
    logic [15:0] vCnt;
    logic [15:0] barPos;
    logic [2:0]  barIdx;
    logic [2:0]  patLatch;
    logic [23:0] colorLatch;

    logic        lastPixel;
    logic        frameStart;
    logic [2:0]  curPattern;
    logic [23:0] curColor;
    logic        inActive;
    logic        inFrame;
    logic        hsLow;
    logic        vsLow;
    logic [7:0]  diag;
    logic [23:0] barColor;
    logic [23:0] pixel;

    // Region decode from the counters; at frame start the live pattern inputs are used so pixel (0,0) already reflects the new latch
    always_comb begin
        lastPixel  = (hCnt == H_LAST) && (vCnt == V_LAST);
        frameStart = (state == RUN) && (hCnt == 16'd0) && (vCnt == 16'd0);
        curPattern = frameStart ? iPattern : patLatch;
        curColor   = frameStart ? iColor : colorLatch;
        inActive   = (hCnt < H_ACT_END) && (vCnt < V_ACT_END);
        inFrame    = (vCnt < V_ACT_END);
        hsLow      = (hCnt >= HS_BEGIN) && (hCnt < HS_END);
        vsLow      = (vCnt >= VS_BEGIN) && (vCnt < VS_END);
        diag       = hCnt[7:0] + vCnt[7:0] + oFrameCnt[7:0];
    end

    // Next-state: a stop request only takes effect once the current frame's last pixel has gone out
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (iEnable) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (!iEnable) begin
                    nextState = lastPixel ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (iEnable) begin
                    nextState = RUN;
                end else if (lastPixel) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Colour-bar lookup, left to right
    always_comb begin
        barColor = 24'h000000;
        case (barIdx)
            3'd0: barColor = 24'hFFFFFF;
            3'd1: barColor = 24'hFFFF00;
            3'd2: barColor = 24'h00FFFF;
            3'd3: barColor = 24'h00FF00;
            3'd4: barColor = 24'hFF00FF;
            3'd5: barColor = 24'hFF0000;
            3'd6: barColor = 24'h0000FF;
            default: barColor = 24'h000000;
        endcase
    end

    // Pixel content for the current counter position; black outside the active window
    always_comb begin
        pixel = 24'h000000;
        if (inActive) begin
            case (curPattern)
                3'd0: pixel = curColor;
                3'd1: pixel = barColor;
                3'd2: pixel = {hCnt[7:0], hCnt[7:0], hCnt[7:0]};
                3'd3: pixel = (hCnt[4] ^ vCnt[4]) ? 24'hFFFFFF : 24'h000000;
                3'd4: pixel = {diag, diag, diag};
                default: pixel = 24'h000000;
            endcase
        end
    end

    // Control FSM with raster counters; counters sit at zero while idle
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            hCnt  <= 16'd0;
            vCnt  <= 16'd0;
            oBusy <= 1'b0;
        end else begin
            state <= nextState;
            oBusy <= (nextState != IDLE);
            if (state == IDLE) begin
                hCnt <= 16'd0;
                vCnt <= 16'd0;
            end else if (hCnt == H_LAST) begin
                hCnt <= 16'd0;
                vCnt <= (vCnt == V_LAST) ? 16'd0 : vCnt + 16'd1;
            end else begin
                hCnt <= hCnt + 16'd1;
            end
        end
    end

    // Bar index tracks hCnt with a per-bar pixel counter; index saturates so the last bar absorbs the remainder
    always_ff @(posedge iClk) begin
        if (iRst || (state == IDLE) || (hCnt == H_LAST)) begin
            barIdx <= 3'd0;
            barPos <= 16'd0;
        end else if (barPos == BAR_LAST) begin
            if (barIdx != 3'd7) begin
                barIdx <= barIdx + 3'd1;
                barPos <= 16'd0;
            end
        end else begin
            barPos <= barPos + 16'd1;
        end
    end

    // Pattern select and solid colour are frozen for the whole frame at its first pixel
    always_ff @(posedge iClk) begin
        if (iRst) begin
            patLatch   <= 3'd0;
            colorLatch <= 24'h000000;
        end else if (frameStart) begin
            patLatch   <= iPattern;
            colorLatch <= iColor;
        end
    end

    // Registered video outputs; idle presents blank video with inactive syncs
    always_ff @(posedge iClk) begin
        if (iRst || (state == IDLE)) begin
            oR          <= 8'd0;
            oG          <= 8'd0;
            oB          <= 8'd0;
            oHSync      <= 1'b1;
            oVSync      <= 1'b1;
            oLineValid  <= 1'b0;
            oFrameValid <= 1'b0;
        end else begin
            {oR, oG, oB} <= pixel;
            oHSync       <= !hsLow;
            oVSync       <= !vsLow;
            oLineValid   <= inActive;
            oFrameValid  <= inFrame;
        end
    end

    // Completed-frame counter, bumped as the counters leave the last pixel
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oFrameCnt <= 16'd0;
        end else if ((state != IDLE) && lastPixel) begin
            oFrameCnt <= oFrameCnt + 16'd1;
        end
    end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Stream source for the camera-side video interface. It generates R/G/B pixels with HSync, VSync, LineValid and FrameValid from parameterised raster timing. The outputs drive the image processing pipeline's `iR/iG/iB/iHSync/iVSync/iLineValid/iFrameValid` inputs in place of the camera, for bring-up and regression. Output content is one of several test patterns selected per frame.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, VSync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- iClk  in  1  pixel clock
- iRst  in  1  reset, synchronous, active-high
- iEnable  in  1  run request
- iPattern  in  3  pattern select
- iColor  in  24  solid colour {R,G,B} for pattern 0
- oR, oG, oB  out  8 each  pixel data
- oHSync  out  1  horizontal sync, active-low
- oVSync  out  1  vertical sync, active-low
- oLineValid  out  1  active pixel on this cycle
- oFrameValid  out  1  within active lines of a frame
- oFrameCnt  out  16  completed frames, wraps at 0xFFFF→0
- oBusy  out  1  state ≠ IDLE

## Operation
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 800×525.
- Counters: hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1.
  - hcnt increments every RUN/DRAIN cycle and wraps to 0.
  - vcnt increments on the hcnt wrap and wraps to 0.
- Region decode, from counters:
  - active: hcnt<H_ACTIVE && vcnt<V_ACTIVE
  - frame-valid: vcnt<V_ACTIVE
  - hsync-low: H_ACTIVE+H_FRONT ≤ hcnt < H_ACTIVE+H_FRONT+H_SYNC, on every line including blanking lines
  - vsync-low: V_ACTIVE+V_FRONT ≤ vcnt < V_ACTIVE+V_FRONT+V_SYNC, over whole lines
- FSM:
  - IDLE: counters held at 0. iEnable=1 → RUN.
  - RUN: counters advance. If iEnable=0 is sampled at any point, go to DRAIN.
  - DRAIN: counters advance. At the last pixel of the frame (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1), go to IDLE. iEnable re-asserting in DRAIN returns to RUN without a gap.
  - RUN at the last pixel of the frame with iEnable=1 continues with the next frame, back-to-back.
- Frames are never truncated. A started frame always completes its full V_TOTAL lines.
- Pattern latch: iPattern and iColor are captured when the counters are at (0,0) in RUN (the first cycle of each frame). The latched value is constant for the whole frame.
- Patterns (active pixels only; RGB=0 outside active):
  - 0: iColor latched
  - 1: 8 vertical bars, each BAR_W=H_ACTIVE/8 wide (integer division; last bar absorbs the remainder). Colours left→right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. The bar index comes from an incrementing counter that saturates at 7; no divider.
  - 2: grey ramp, R=G=B=hcnt[7:0]
  - 3: checkerboard, hcnt[4]^vcnt[4] ? FFFFFF : 000000
  - 4: moving diagonal, R=G=B=(hcnt+vcnt+oFrameCnt)[7:0] (8-bit modular add)
  - 5–7: 000000
- oFrameCnt increments by 1 on the cycle the counters leave (H_TOTAL-1, V_TOTAL-1).

## Timing
- All outputs are registered, with 1-cycle latency from the counter state.
- Reset values: oR=oG=oB=0, oHSync=1, oVSync=1, oLineValid=0, oFrameValid=0, oFrameCnt=0, oBusy=0. Internal: state IDLE, hcnt=vcnt=0.
- In IDLE the outputs hold their reset values (syncs inactive-high); oFrameCnt is retained.
- Start sequence:
  - Edge k samples iEnable=1 in IDLE; at edge k+1 the state is RUN with counters at (0,0).
  - At edge k+2 the outputs present pixel (0,0): oLineValid=1, oFrameValid=1.
  - oBusy=1 from edge k+1.
- iRst mid-frame: at the next edge everything returns to reset values, regardless of state. oFrameCnt clears.
- Per line (defaults), relative to the oLineValid rise:
  - oLineValid high 640 cycles
  - oHSync falls 656 cycles after the rise and is low 96 cycles
  - next oLineValid rise 800 cycles after the previous one
- oFrameValid is high for 480×800 consecutive cycles.
- oVSync falls 490 line-times after the oFrameValid rise and is low 2×800 cycles.

## Test plan
- Reset: hold iRst 3 cycles with iEnable=1 → all outputs at reset values, oBusy=0. After release, the first oLineValid=1 appears exactly 2 cycles after the first sampled iEnable.
- Line/frame timing, defaults:
  - oLineValid high 640, HSync low 96 starting 656 after the LineValid rise, period 800
  - oFrameValid high 384000 cycles, VSync low 1600 cycles, frame period 420000
  - oFrameCnt=1 after the first frame
- Pattern 1:
  - pixel 0 → FFFFFF; pixel 79 → FFFFFF; pixel 80 → FFFF00; pixel 639 → 000000
  - with H_ACTIVE=20: BAR_W=2, pixels 14–19 are black
- Pattern latch: switch iPattern 0→3 mid-frame → current frame remains iColor; next frame shows checkerboard, with pixel (16,0)=FFFFFF and (16,16)=000000.
- Disable: drop iEnable at line 100 → frame completes; oBusy falls 1 cycle after the last pixel (799,524); oFrameCnt increments once. Re-asserting iEnable in DRAIN → next frame starts back-to-back.
- Reset mid-line (hcnt=300, vcnt=50) → next cycle all outputs at reset values, oFrameCnt=0; restart timing matches the start sequence.
